// File: rtl/hazard_scoreboard.sv
// Hazard unit for the five-stage pipeline: forwarding, load-use/branch stalls, mul/div scoreboard, stall counter.
// Stall/flush/forward outputs are combinational; scoreboard and counter state update on the rising clock edge.
module hazard_scoreboard #(
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] reg_write_addr_d,
    input  logic             reg_we_d,
    input  logic [1:0]       branch_d,
    input  logic [1:0]       jump_d,
    input  logic             md_op_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] reg_write_addr_e,
    input  logic             sel_reg_write_data_e,
    input  logic             reg_we_e,
    input  logic             md_issue_e,
    input  logic             md_div_e,
    input  logic [REG_W-1:0] reg_write_addr_m,
    input  logic             sel_reg_write_data_m,
    input  logic             reg_we_m,
    input  logic [REG_W-1:0] reg_write_addr_w,
    input  logic             reg_we_w,
    input  logic             predict_miss,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             forward_a_d,
    output logic             forward_b_d,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             md_busy,
    output logic             md_wb_valid,
    output logic [REG_W-1:0] md_wb_addr,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 2);

    typedef enum logic [1:0] {IDLE, BUSY, WB} md_state_t;

    md_state_t        state, state_nxt;
    logic [REG_W-1:0] pend_dest, dest_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;

    logic lw_stall, branch_stall, md_raw_stall, md_waw_stall, md_struct_stall;

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    function automatic logic md_hit(input logic [REG_W-1:0] r, input logic busy,
                                    input logic [REG_W-1:0] dest, input logic issue,
                                    input logic [REG_W-1:0] issue_dest);
        return (busy && reg_match(r, dest)) || (issue && reg_match(r, issue_dest));
    endfunction

    always_comb begin
        forward_a_e = 2'b00;
        if (reg_we_m && reg_match(rs_e, reg_write_addr_m))
            forward_a_e = 2'b10;
        else if (reg_we_w && reg_match(rs_e, reg_write_addr_w))
            forward_a_e = 2'b01;
    end

    always_comb begin
        forward_b_e = 2'b00;
        if (reg_we_m && reg_match(rt_e, reg_write_addr_m))
            forward_b_e = 2'b10;
        else if (reg_we_w && reg_match(rt_e, reg_write_addr_w))
            forward_b_e = 2'b01;
    end

    assign forward_a_d = reg_we_m && reg_match(rs_d, reg_write_addr_m);
    assign forward_b_d = reg_we_m && reg_match(rt_d, reg_write_addr_m);

    assign lw_stall = sel_reg_write_data_e &&
                      (reg_match(rs_d, reg_write_addr_e) || reg_match(rt_d, reg_write_addr_e));

    assign branch_stall = ((branch_d != 2'b00) || jump_d[1]) &&
        ((reg_we_e && (reg_match(rs_d, reg_write_addr_e) || reg_match(rt_d, reg_write_addr_e))) ||
         (sel_reg_write_data_m &&
          (reg_match(rs_d, reg_write_addr_m) || reg_match(rt_d, reg_write_addr_m))));

    assign md_busy    = (state != IDLE);
    assign md_wb_addr = pend_dest;

    assign md_raw_stall = md_hit(rs_d, md_busy, pend_dest, md_issue_e, reg_write_addr_e) ||
                          md_hit(rt_d, md_busy, pend_dest, md_issue_e, reg_write_addr_e);
    assign md_waw_stall = reg_we_d &&
                          md_hit(reg_write_addr_d, md_busy, pend_dest, md_issue_e, reg_write_addr_e);
    assign md_struct_stall = md_op_d && (md_busy || md_issue_e);

    assign stall_d = lw_stall | branch_stall | md_raw_stall | md_waw_stall | md_struct_stall;
    assign stall_f = stall_d;
    assign flush_e = stall_d | predict_miss;
    assign flush_d = predict_miss | (jump_d != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pend_dest <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            pend_dest <= dest_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // The W stage owns the write port; a waiting result simply holds in WB.
    always_comb begin
        state_nxt   = state;
        dest_nxt    = pend_dest;
        cnt_nxt     = cnt;
        md_wb_valid = 1'b0;
        case (state)
            IDLE: begin
                if (md_issue_e) begin
                    state_nxt = BUSY;
                    dest_nxt  = reg_write_addr_e;
                    cnt_nxt   = md_div_e ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0)
                    state_nxt = WB;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            WB: begin
                md_wb_valid = !reg_we_w;
                if (!reg_we_w)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall_d && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed and random cycles against a cycle-count reference model.
module tb_hazard_scoreboard;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rs_d = '0, rt_d = '0, reg_write_addr_d = '0;
    logic       reg_we_d = 1'b0;
    logic [1:0] branch_d = '0, jump_d = '0;
    logic       md_op_d = 1'b0;
    logic [4:0] rs_e = '0, rt_e = '0, reg_write_addr_e = '0;
    logic       sel_reg_write_data_e = 1'b0, reg_we_e = 1'b0, md_issue_e = 1'b0, md_div_e = 1'b0;
    logic [4:0] reg_write_addr_m = '0;
    logic       sel_reg_write_data_m = 1'b0, reg_we_m = 1'b0;
    logic [4:0] reg_write_addr_w = '0;
    logic       reg_we_w = 1'b0, predict_miss = 1'b0;
    logic       stall_f, stall_d, flush_d, flush_e, forward_a_d, forward_b_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic       md_busy, md_wb_valid;
    logic [4:0] md_wb_addr;
    logic [CNT_W-1:0] stall_cycles;

    hazard_scoreboard #(.REG_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .reg_write_addr_d(reg_write_addr_d), .reg_we_d(reg_we_d),
        .branch_d(branch_d), .jump_d(jump_d), .md_op_d(md_op_d),
        .rs_e(rs_e), .rt_e(rt_e), .reg_write_addr_e(reg_write_addr_e),
        .sel_reg_write_data_e(sel_reg_write_data_e), .reg_we_e(reg_we_e),
        .md_issue_e(md_issue_e), .md_div_e(md_div_e),
        .reg_write_addr_m(reg_write_addr_m), .sel_reg_write_data_m(sel_reg_write_data_m),
        .reg_we_m(reg_we_m), .reg_write_addr_w(reg_write_addr_w), .reg_we_w(reg_we_w),
        .predict_miss(predict_miss),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .md_busy(md_busy), .md_wb_valid(md_wb_valid), .md_wb_addr(md_wb_addr),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       reset;
        logic [4:0] rs_d, rt_d, wa_d;
        logic       we_d;
        logic [1:0] branch_d, jump_d;
        logic       md_op_d;
        logic [4:0] rs_e, rt_e, wa_e;
        logic       sel_e, we_e, issue, div;
        logic [4:0] wa_m;
        logic       sel_m, we_m;
        logic [4:0] wa_w;
        logic       we_w, miss;
    } stim_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        stall, flush_d, flush_e, fad, fbd;
        logic [1:0]  fae, fbe;
        logic        busy, wbv;
        logic [4:0]  wba;
        logic [3:0]  sc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: one outstanding mul/div, known by the cycle its result becomes eligible.
    bit         m_pend = 0;
    logic [4:0] m_dest = '0;
    int         m_ready = 0;
    int         m_cyc = 0;
    int         m_cnt = 0;

    function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    task automatic chk(input string name, input int act, input int req, input int cyc);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        bit lw, br, raw, waw, st, wb;
        @(posedge clk);
        #1;
        reset = s.reset; rs_d = s.rs_d; rt_d = s.rt_d; reg_write_addr_d = s.wa_d;
        reg_we_d = s.we_d; branch_d = s.branch_d; jump_d = s.jump_d; md_op_d = s.md_op_d;
        rs_e = s.rs_e; rt_e = s.rt_e; reg_write_addr_e = s.wa_e;
        sel_reg_write_data_e = s.sel_e; reg_we_e = s.we_e; md_issue_e = s.issue; md_div_e = s.div;
        reg_write_addr_m = s.wa_m; sel_reg_write_data_m = s.sel_m; reg_we_m = s.we_m;
        reg_write_addr_w = s.wa_w; reg_we_w = s.we_w; predict_miss = s.miss;

        if (s.reset) begin
            m_pend = 0; m_dest = '0; m_cnt = 0;
        end
        e = '0;
        e.cyc = 32'(m_cyc);
        e.fae = (s.we_m && dep(s.rs_e, s.wa_m)) ? 2'b10 : (s.we_w && dep(s.rs_e, s.wa_w)) ? 2'b01 : 2'b00;
        e.fbe = (s.we_m && dep(s.rt_e, s.wa_m)) ? 2'b10 : (s.we_w && dep(s.rt_e, s.wa_w)) ? 2'b01 : 2'b00;
        e.fad = s.we_m && dep(s.rs_d, s.wa_m);
        e.fbd = s.we_m && dep(s.rt_d, s.wa_m);
        lw  = s.sel_e && (dep(s.rs_d, s.wa_e) || dep(s.rt_d, s.wa_e));
        br  = ((s.branch_d != 0) || s.jump_d[1]) &&
              ((s.we_e && (dep(s.rs_d, s.wa_e) || dep(s.rt_d, s.wa_e))) ||
               (s.sel_m && (dep(s.rs_d, s.wa_m) || dep(s.rt_d, s.wa_m))));
        raw = (m_pend && (dep(s.rs_d, m_dest) || dep(s.rt_d, m_dest))) ||
              (s.issue && (dep(s.rs_d, s.wa_e) || dep(s.rt_d, s.wa_e)));
        waw = s.we_d && ((m_pend && dep(s.wa_d, m_dest)) || (s.issue && dep(s.wa_d, s.wa_e)));
        st  = s.md_op_d && (m_pend || s.issue);
        wb  = m_pend && (m_cyc >= m_ready) && !s.we_w;
        e.stall   = lw | br | raw | waw | st;
        e.flush_e = e.stall | s.miss;
        e.flush_d = s.miss | (s.jump_d != 0);
        e.busy    = m_pend;
        e.wbv     = wb;
        e.wba     = m_dest;
        e.sc      = 4'(m_cnt);
        exp_q.push_back(e);

        if (!s.reset) begin
            if (m_pend && wb) m_pend = 0;
            else if (!m_pend && s.issue) begin
                m_pend  = 1;
                m_dest  = s.wa_e;
                m_ready = m_cyc + (s.div ? DIV_LAT : MUL_LAT);
            end
            if (e.stall && m_cnt < 15) m_cnt++;
        end
        m_cyc++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("stall_d", int'(stall_d), int'(mon_e.stall), int'(mon_e.cyc));
            chk("stall_f", int'(stall_f), int'(mon_e.stall), int'(mon_e.cyc));
            chk("flush_d", int'(flush_d), int'(mon_e.flush_d), int'(mon_e.cyc));
            chk("flush_e", int'(flush_e), int'(mon_e.flush_e), int'(mon_e.cyc));
            chk("forward", int'({forward_a_d, forward_b_d, forward_a_e, forward_b_e}),
                int'({mon_e.fad, mon_e.fbd, mon_e.fae, mon_e.fbe}), int'(mon_e.cyc));
            chk("md_busy", int'(md_busy), int'(mon_e.busy), int'(mon_e.cyc));
            chk("md_wb_valid", int'(md_wb_valid), int'(mon_e.wbv), int'(mon_e.cyc));
            chk("md_wb_addr", int'(md_wb_addr), int'(mon_e.wba), int'(mon_e.cyc));
            chk("stall_cycles", int'(stall_cycles), int'(mon_e.sc), int'(mon_e.cyc));
        end
    end

    initial begin
        stim_t s;
        s = '0; s.reset = 1'b1;
        repeat (2) apply(s);
        s = '0;
        apply(s);
        // Forwarding priority and the $0 exclusion.
        s.rs_e = 5'd3; s.wa_m = 5'd3; s.we_m = 1'b1; s.wa_w = 5'd3; s.we_w = 1'b1;
        apply(s);
        s.rs_e = 5'd0;
        apply(s);
        s.rs_e = 5'd3; s.rt_e = 5'd3; s.we_m = 1'b0;
        apply(s);
        // Load-use, then branch dependencies on E and on an M load.
        s = '0; s.sel_e = 1'b1; s.we_e = 1'b1; s.wa_e = 5'd5; s.rs_d = 5'd5;
        apply(s);
        s = '0; apply(s);
        s = '0; s.branch_d = 2'b01; s.rt_d = 5'd6; s.wa_e = 5'd6; s.we_e = 1'b1;
        apply(s);
        s = '0; s.jump_d = 2'b10; s.rs_d = 5'd7; s.wa_m = 5'd7; s.sel_m = 1'b1;
        apply(s);
        s = '0; s.jump_d = 2'b01; apply(s);
        s = '0; s.miss = 1'b1; apply(s);
        // Multiply to r8 with a dependent reader held in D.
        s = '0; s.issue = 1'b1; s.wa_e = 5'd8; s.rs_d = 5'd8;
        apply(s);
        s.issue = 1'b0; s.wa_e = 5'd0;
        repeat (6) apply(s);
        // Divide whose writeback loses the port for two cycles.
        s = '0; s.issue = 1'b1; s.div = 1'b1; s.wa_e = 5'd9;
        apply(s);
        s = '0;
        repeat (31) apply(s);
        s.we_w = 1'b1; s.wa_w = 5'd2;
        repeat (2) apply(s);
        s = '0;
        repeat (3) apply(s);
        // Structural stall while the unit is occupied.
        s = '0; s.issue = 1'b1; s.wa_e = 5'd10;
        apply(s);
        s = '0; s.md_op_d = 1'b1;
        repeat (6) apply(s);
        // Reset in the middle of a divide discards it.
        s = '0; s.issue = 1'b1; s.div = 1'b1; s.wa_e = 5'd11;
        apply(s);
        s = '0;
        repeat (5) apply(s);
        s.reset = 1'b1; apply(s);
        s.reset = 1'b0;
        repeat (40) apply(s);
        // Issue while busy is ignored; WAW against the pending destination.
        s = '0; s.issue = 1'b1; s.wa_e = 5'd12;
        apply(s);
        s.wa_e = 5'd13;
        apply(s);
        s = '0; s.we_d = 1'b1; s.wa_d = 5'd12;
        repeat (5) apply(s);
        // Held stall drives the 4-bit counter to saturation.
        s = '0; s.sel_e = 1'b1; s.wa_e = 5'd5; s.rt_d = 5'd5;
        repeat (20) apply(s);

        repeat (2000) begin
            s = '0;
            s.reset    = ($urandom_range(0, 49) == 0);
            s.rs_d     = 5'($urandom_range(0, 7));
            s.rt_d     = 5'($urandom_range(0, 7));
            s.wa_d     = 5'($urandom_range(0, 7));
            s.we_d     = 1'($urandom_range(0, 1));
            s.branch_d = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            s.jump_d   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            s.md_op_d  = ($urandom_range(0, 3) == 0);
            s.rs_e     = 5'($urandom_range(0, 7));
            s.rt_e     = 5'($urandom_range(0, 7));
            s.wa_e     = 5'($urandom_range(0, 7));
            s.sel_e    = ($urandom_range(0, 3) == 0);
            s.we_e     = 1'($urandom_range(0, 1));
            s.issue    = m_pend ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
            s.div      = ($urandom_range(0, 3) == 0);
            s.wa_m     = 5'($urandom_range(0, 7));
            s.sel_m    = ($urandom_range(0, 3) == 0);
            s.we_m     = 1'($urandom_range(0, 1));
            s.wa_w     = 5'($urandom_range(0, 7));
            s.we_w     = 1'($urandom_range(0, 1));
            s.miss     = ($urandom_range(0, 9) == 0);
            apply(s);
        end

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
